proc_req_sequencer: RTL and testbench

Parametrised, programmable processor-side request generator for the directory-based coherence testbench. It replays a loadable program of read, write, idle and halt entries toward a cache controller over a valid/ready request channel. It waits for read responses and records the returned data. It replaces fixed per-processor instruction ROMs with one reusable block, instantiated once per processor node.

---
 rtl/proc_req_sequencer_pkg.sv | 24 ++
 rtl/proc_req_sequencer.sv | 148 ++++++++++++++
 tb/tb_proc_req_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/proc_req_sequencer_pkg.sv
// rtl/proc_req_sequencer_pkg.sv - shared constants for the processor request sequencer
// Purpose: program entry kinds, request op encoding and sequencer state encoding.
// Ports: none (package).
package proc_req_sequencer_pkg;

  // Entry kind field, top two bits of a program word. KIND_RSVD behaves as NOP.
  typedef enum logic [1:0] {
    KIND_NOP  = 2'd0,
    KIND_REQ  = 2'd1,
    KIND_HALT = 2'd2,
    KIND_RSVD = 2'd3
  } kind_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/proc_req_sequencer.sv
// rtl/proc_req_sequencer.sv - programmable processor-side request generator
// Purpose: replays a loaded program of NOP/REQ/HALT entries as valid/ready
//   requests, waits for read responses and records the last read data.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   load_en/load_idx/load_word  program write port (honoured only when not busy)
//   start                       run program from slot 0 (ignored while busy)
//   req_valid/req_ready         request handshake; req_op/req_addr/req_data payload
//   rsp_valid/rsp_data          read response, accepted only while waiting for one
//   last_rd_data                most recently captured read data
//   issued_count                handshakes accepted in the current run
//   busy, done                  run in progress / run finished
module proc_req_sequencer
  import proc_req_sequencer_pkg::*;
#(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int IW     = 2 + 1 + ADDR_W + DATA_W,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [PW-1:0]     load_idx,
  input  logic [IW-1:0]     load_word,
  input  logic              start,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_op,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] last_rd_data,
  output logic [CW-1:0]     issued_count,
  output logic              busy,
  output logic              done
);

  // Program memory is deliberately not reset so a run can be replayed after rst_n.
  logic [IW-1:0] prog_q [DEPTH];

  state_e            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] last_q, last_d;

  logic [IW-1:0]     entry;
  logic [1:0]        ent_kind;
  logic              ent_op;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
  logic              pc_last;

  assign entry    = prog_q[pc_q];
  assign ent_kind = entry[IW-1 -: 2];
  assign ent_op   = entry[ADDR_W + DATA_W];
  assign ent_addr = entry[ADDR_W + DATA_W - 1 -: ADDR_W];
  assign ent_data = entry[DATA_W-1:0];
  assign pc_last  = (pc_q == PW'(DEPTH - 1));

  assign busy         = (state_q == ST_EXEC) || (state_q == ST_WAIT_RSP);
  assign done         = (state_q == ST_DONE);
  assign issued_count = cnt_q;
  assign last_rd_data = last_q;

  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      prog_q[load_idx] <= load_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_addr  = '0;
    req_data  = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (ent_kind == KIND_REQ) begin
          req_valid = 1'b1;
          req_op    = ent_op;
          req_addr  = ent_addr;
          req_data  = (ent_op == OP_WRITE) ? ent_data : '0;
          if (req_ready) begin
            cnt_d = cnt_q + CW'(1);
            if (ent_op == OP_WRITE) begin
              if (pc_last) state_d = ST_DONE;
              else         pc_d    = pc_q + PW'(1);
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end
        end else if (ent_kind == KIND_HALT) begin
          state_d = ST_DONE;
        end else begin
          // NOP and reserved kinds: one cycle, then advance without wrapping.
          if (pc_last) state_d = ST_DONE;
          else         pc_d    = pc_q + PW'(1);
        end
      end

      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          last_d = rsp_data;
          if (pc_last) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = pc_q + PW'(1);
            state_d = ST_EXEC;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_proc_req_sequencer.sv
// tb/tb_proc_req_sequencer.sv - randomized self-checking bench for proc_req_sequencer
module tb_proc_req_sequencer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int IW     = 2 + 1 + ADDR_W + DATA_W;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int RW     = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic [PW-1:0]     load_idx;
  logic [IW-1:0]     load_word;
  logic              start;
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] last_rd_data;
  logic [CW-1:0]     issued_count;
  logic              busy;
  logic              done;

  proc_req_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_idx(load_idx), .load_word(load_word),
    .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .last_rd_data(last_rd_data), .issued_count(issued_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [IW-1:0]     prog [DEPTH];
  logic [DATA_W-1:0] exp_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [IW-1:0] pack(input logic [1:0] kind, input logic op,
                                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {kind, op, a, d};
  endfunction

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_idx  = PW'(i);
      load_word = prog[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic rand_prog();
    for (int i = 0; i < DEPTH; i++) begin
      int r;
      r = $urandom_range(9);
      if (r < 2)       prog[i] = pack(2'd0, 1'($urandom), 8'($urandom), 8'($urandom));
      else if (r == 2) prog[i] = pack(2'd3, 1'($urandom), 8'($urandom), 8'($urandom));
      else if (r == 9) prog[i] = pack(2'd2, 1'($urandom), 8'($urandom), 8'($urandom));
      else             prog[i] = pack(2'd1, 1'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  // Runs the loaded program once against a transaction-level expectation:
  // the ordered list of requests implied by the program, plus response capture rules.
  task automatic run_prog(input int ready_pct, input bit inject_load);
    logic [RW-1:0] q[$];
    logic [RW-1:0] prev;
    int  idx, cyc;
    bit  pending, stall_prev;
    logic [RW-1:0] cur;

    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (prog[i][IW-1 -: 2] == 2'd2) break;
      if (prog[i][IW-1 -: 2] == 2'd1)
        q.push_back({prog[i][RW-1], prog[i][DATA_W +: ADDR_W],
                     prog[i][RW-1] ? prog[i][DATA_W-1:0] : 8'h00});
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; pending = 0; stall_prev = 0; prev = '0;
    check_eq("first_eval", {31'b0, req_valid}, {31'b0, prog[0][IW-1 -: 2] == 2'd1});

    while (!done && cyc < 2000) begin
      cur = {req_op, req_addr, req_data};
      if (!req_valid) check_eq("idle_fields_zero", 32'(cur), 32'd0);
      if (stall_prev) check_eq("stall_stable", 32'({req_valid, cur}), 32'({1'b1, prev}));

      req_ready = ($urandom_range(99) < ready_pct);
      rsp_valid = ($urandom_range(99) < 40);
      rsp_data  = DATA_W'($urandom);
      load_en   = inject_load && (cyc == 2);
      load_idx  = '0;
      load_word = pack(2'd2, 1'b0, 8'h00, 8'h00);

      if (rsp_valid && pending) begin
        exp_last = rsp_data;
        pending  = 0;
      end
      if (req_valid && req_ready) begin
        check_eq("issued_running", 32'(issued_count), 32'(idx));
        if (idx < q.size()) check_eq("req_payload", 32'(cur), 32'(q[idx]));
        else                check_eq("extra_req", 32'(idx), 32'(q.size()));
        if (!req_op) pending = 1;
        idx++;
      end
      stall_prev = req_valid && !req_ready;
      prev = cur;
      cyc++;
      @(negedge clk);
    end

    load_en   = 1'b0;
    rsp_valid = 1'b0;
    check_eq("done_reached", {31'b0, done}, 32'd1);
    check_eq("req_total", 32'(idx), 32'(q.size()));
    check_eq("rsp_pending", {31'b0, pending}, 32'd0);
    check_eq("issued_final", 32'(issued_count), 32'(q.size()));
    check_eq("last_rd_data", 32'(last_rd_data), 32'(exp_last));
    check_eq("busy_at_done", {31'b0, busy}, 32'd0);

    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_done_quiet", {30'b0, req_valid, done}, 32'd1);
    end
    req_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_idx = '0; load_word = '0; start = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    exp_last = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_state", {25'b0, req_valid, busy, done, issued_count}, 32'd0);
    check_eq("reset_last", 32'(last_rd_data), 32'd0);
    check_eq("reset_fields", 32'({req_op, req_addr, req_data}), 32'd0);
    rst_n = 1'b1;

    // Directed program: read, write, NOP, read, read, HALT.
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    prog[0] = pack(2'd1, 1'b0, 8'h04, 8'h00);
    prog[1] = pack(2'd1, 1'b1, 8'h04, 8'h80);
    prog[2] = pack(2'd0, 1'b0, 8'h00, 8'h00);
    prog[3] = pack(2'd1, 1'b0, 8'h04, 8'h00);
    prog[4] = pack(2'd1, 1'b0, 8'h00, 8'h00);
    prog[5] = pack(2'd2, 1'b0, 8'h00, 8'h00);
    load_all();
    run_prog(100, 0);
    run_prog(30, 0);

    // Reset while waiting for a read response, then replay.
    @(negedge clk);
    start = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("rst_pre_valid", {31'b0, req_valid}, 32'd1);
    @(negedge clk);
    req_ready = 1'b0;
    check_eq("rst_pre_wait", {30'b0, busy, req_valid}, 32'd2);
    check_eq("rst_pre_issued", 32'(issued_count), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = '0;
    check_eq("rst_mid_state", {25'b0, req_valid, busy, done, issued_count}, 32'd0);
    check_eq("rst_mid_last", 32'(last_rd_data), 32'd0);
    run_prog(100, 0);

    // Every slot a write of i to address i: no HALT, no wrap; load attempt while busy.
    for (int i = 0; i < DEPTH; i++) prog[i] = pack(2'd1, 1'b1, 8'(i), 8'(i));
    load_all();
    run_prog(60, 1);

    for (int t = 0; t < 8; t++) begin
      rand_prog();
      load_all();
      run_prog(20 + 10 * t, t[0]);
    end

    // Reload slot 0 as HALT in the same cycle as start, from DONE.
    prog[0] = pack(2'd2, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    load_en = 1'b1; load_idx = '0; load_word = prog[0]; start = 1'b1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    check_eq("halt_t1", {29'b0, req_valid, busy, done}, 32'd2);
    @(negedge clk);
    check_eq("halt_t2", {29'b0, req_valid, busy, done}, 32'd1);
    check_eq("halt_issued", 32'(issued_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
